// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
// Included by seq_multiplier and its ripple-carry accumulate adder.
package seq_mult_pkg;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mult_state_t;

    // Keeps only the low n multiplier bits; n >= DATA_W keeps everything.
    function automatic logic [DATA_W-1:0] operand_mask(input int n);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < DATA_W; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_multiplier_full_adder.sv
// full_adder: 64-bit ripple-carry adder used as the multiplier's accumulate path.
// Carry-out of the top bit is intentionally not produced (results wrap mod 2^64).
module full_adder
    import seq_mult_pkg::*;
(
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic [DATA_W-1:0] out
);

    logic [DATA_W-1:0] w_carry;
    logic [DATA_W-1:0] w_half;

    assign w_carry[0] = 1'b0;
    assign w_half     = in1 ^ in2;

    genvar g;
    generate
        for (g = 0; g < DATA_W; g++) begin : g_bit
            assign out[g] = w_half[g] ^ w_carry[g];
            if (g < DATA_W - 1) begin : g_carry
                assign w_carry[g+1] = (in1[g] & in2[g]) | (w_carry[g] & w_half[g]);
            end
        end
    endgenerate

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: one multiplier bit per cycle, low 64 bits kept.
// Optional macro MULT_EARLY_EXIT_EN ends the run once the remaining multiplier is zero.
//
// state  | meaning
// S_IDLE | ready, waiting for start
// S_RUN  | one shift-and-add step per cycle
// S_DONE | one-cycle done pulse, product valid
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int N = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam logic [DATA_W-1:0] B_MASK = operand_mask(N);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N);

    mult_state_t       r_state;
    mult_state_t       w_state_next;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_product;
    logic [CNT_W-1:0]  r_cnt;

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_acc_step;
    logic [DATA_W-1:0] w_mplier_step;
    logic [CNT_W-1:0]  w_cnt_step;
    logic              w_last_step;

    full_adder u_adder (
        .in1 (r_acc),
        .in2 (r_mcand),
        .out (w_sum)
    );

    assign w_acc_step    = r_mplier[0] ? w_sum : r_acc;
    assign w_mplier_step = r_mplier >> 1;
    assign w_cnt_step    = r_cnt + CNT_W'(1);

`ifdef MULT_EARLY_EXIT_EN
    assign w_last_step = (w_cnt_step == CNT_LAST) || (w_mplier_step == '0);
`else
    assign w_last_step = (w_cnt_step == CNT_LAST);
`endif

    assign product = r_product;

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last_step) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= a;
                        r_mplier <= b & B_MASK;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_step;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_step;
                    r_cnt    <= w_cnt_step;
                    // Capture on the final step so product is valid throughout S_DONE.
                    if (w_last_step) begin
                        r_product <= w_acc_step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (N=64) against an arithmetic reference model.
// Latency expectations follow MULT_EARLY_EXIT_EN if the bench is built with it defined.
module tb_seq_multiplier;

    localparam int N = 64;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int n_cmp;
    int n_err;

    seq_multiplier #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mask();
        logic [63:0] m;
        m = '1;
        if (N < 64) m = (64'd1 << N) - 64'd1;
        return m;
    endfunction

    function automatic logic [63:0] ref_mul(input logic [63:0] ta, input logic [63:0] tb);
        return ta * (tb & ref_mask());
    endfunction

    // Cycles spent in RUN: N, or (early exit) the position of the top set bit plus one.
    function automatic int ref_run_cycles(input logic [63:0] tb);
        int steps;
        logic [63:0] bm;
        bm = tb & ref_mask();
        steps = N;
`ifdef MULT_EARLY_EXIT_EN
        steps = 1;
        for (int i = 0; i < 64; i++) begin
            if (bm[i]) steps = i + 1;
        end
        if (steps > N) steps = N;
`endif
        return steps;
    endfunction

    task automatic wait_ready(input string tag);
        int guard;
        guard = 0;
        while (ready !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) chk({tag, "_ready_timeout"}, 64'd1, 64'd0);
    endtask

    // Issues ta*tb; optionally attempts an interfering start at cycle intf_k after accept.
    task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                          input int intf_k, input logic [63:0] ia, input logic [63:0] ib);
        int k;
        int exp_done_k;
        logic [63:0] p0;
        bit stable;
        exp_done_k = ref_run_cycles(tb) + 1;
        wait_ready(tag);
        start = 1'b1;
        a = ta;
        b = tb;
        @(negedge clk);
        start = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        k = 1;
        p0 = product;
        stable = 1'b1;
        while (done !== 1'b1 && k < 300) begin
            if (product !== p0) stable = 1'b0;
            if (k == intf_k) begin
                start = 1'b1;
                a = ia;
                b = ib;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk({tag, "_hold_in_run"}, {63'd0, stable}, 64'd1);
        chk({tag, "_done_cycle"}, 64'(k), 64'(exp_done_k));
        chk({tag, "_product"}, product, ref_mul(ta, tb));
        @(negedge clk);
        chk({tag, "_done_single"}, {63'd0, done}, 64'd0);
        chk({tag, "_ready_after"}, {63'd0, ready}, 64'd1);
        chk({tag, "_product_held"}, product, ref_mul(ta, tb));
    endtask

    initial begin
        bit seen;
        logic [63:0] ra;
        logic [63:0] rb;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_product", product, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("a1_b12", 64'd1, 64'd12, 0, '0, '0);
        run_op("a1000_b4", 64'd1000, 64'd4, 0, '0, '0);
        run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, '0, '0);
        run_op("ignore_busy", 64'd1004, 64'd4, 5, 64'd1008, 64'd100);
        run_op("reissue", 64'd1008, 64'd100, 0, '0, '0);
        run_op("b_zero", 64'd5, 64'd0, 0, '0, '0);
        run_op("b_allones", 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0, '0, '0);
        run_op("b_msb", 64'h0123_4567_89AB_CDEF, 64'h8000_0000_0000_0000, 0, '0, '0);

        // Reset mid-operation aborts with no done pulse.
        wait_ready("abort");
        start = 1'b1;
        a = 64'd7;
        b = 64'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_rst_done", {63'd0, done}, 64'd0);
        chk("abort_rst_product", product, 64'd0);
        chk("abort_rst_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", {63'd0, ready}, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (done === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_done", {63'd0, seen}, 64'd0);
        chk("abort_product_zero", product, 64'd0);

        // Reset wins over a simultaneous start.
        reset = 1'b1;
        start = 1'b1;
        a = 64'd11;
        b = 64'd13;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_prio_ready", {63'd0, ready}, 64'd1);
        chk("rst_prio_busy", {63'd0, busy}, 64'd0);

        for (int i = 0; i < 12; i++) begin
            ra = {$urandom, $urandom};
            case (i % 3)
                0: rb = {$urandom, $urandom};
                1: rb = 64'($urandom_range(0, 255));
                default: rb = {32'd0, $urandom};
            endcase
            run_op($sformatf("rnd%0d", i), ra, rb, 0, '0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have one parameter: N, default 64, number of multiplier bits consumed per operation (legal range 1..64).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on posedge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a new multiply.
REQ-005 SHALL have port: a  input  64  multiplicand, sampled on the accept cycle only.
REQ-006 SHALL have port: b  input  64  multiplier, sampled on the accept cycle only.
REQ-007 SHALL have port: ready  output  1  high only in S_IDLE, so a start is accepted.
REQ-008 SHALL have port: busy  output  1  high in S_RUN and S_DONE.
REQ-009 SHALL have port: done  output  1  single-cycle pulse, asserted in S_DONE.
REQ-010 SHALL have port: product  output  64  registered result, held until the next done.

Function
REQ-011 SHALL implement a three-state FSM: S_IDLE, S_RUN and S_DONE.
REQ-012 SHALL accept start only when ready=1; on accept, SHALL load mcand=a, mplier=b, acc=0 and cnt=0, then enter S_RUN.
REQ-013 SHALL ignore start while busy=1; operands presented during that time SHALL have no effect.
REQ-014 SHALL perform one step per cycle in S_RUN:
  - if mplier[0]=1: acc <= acc + mcand, via the shared adder;
  - mcand <<= 1; mplier >>= 1; cnt++.
REQ-015 SHALL move S_RUN -> S_DONE after the step in which cnt reaches N.
REQ-016 SHALL, in S_DONE, assert done=1 for exactly one cycle, with product equal to the final acc on that cycle; the next state SHALL be S_IDLE.
REQ-017 SHALL give the following latency, with accept at cycle t: RUN occupies t+1..t+N, done is high at t+N+1, and ready is high again at t+N+2.
REQ-018 SHALL compute unsigned arithmetic modulo 2^64 (low 64 bits only), discarding carry-out and bits shifted beyond bit 63.
REQ-019 SHALL give a result equal to the two's-complement low 64 bits of a*b when N=64.
REQ-020 SHALL process only b[N-1:0] when N<64.
REQ-021 SHALL hold product stable from one done pulse until the next; it SHALL NOT change during S_RUN.

Reset
REQ-022 SHALL, with reset=1 at a posedge, force state=S_IDLE, ready=1, busy=0, done=0, product=0, acc=0 and cnt=0.
REQ-023 SHALL, on reset mid-operation, abort the operation with no done pulse; ready SHALL be high on the cycle after reset deasserts.
REQ-024 SHALL give reset priority over start on the same cycle.

Configuration
REQ-025 SHALL support macro MULT_EARLY_EXIT_EN.
REQ-026 SHALL, when MULT_EARLY_EXIT_EN is defined, go S_RUN -> S_DONE after any step whose updated mplier equals 0, or when cnt reaches N, whichever is first; with b=0 the block SHALL spend one RUN cycle and pulse done at t+2.
REQ-027 SHALL, when MULT_EARLY_EXIT_EN is undefined, use the fixed N-cycle RUN of REQ-017 regardless of operand values.
REQ-028 SHALL produce identical product values in both configurations.

Structure
REQ-029 SHALL place in shared package seq_mult_pkg:
  - DATA_W=64;
  - CNT_W=7;
  - typedef enum logic [1:0] mult_state_t {S_IDLE, S_RUN, S_DONE}.
REQ-030 SHALL instantiate exactly one existing full_adder (64-bit ripple adder, ports in1/in2/out) as the accumulate datapath, with in1=acc and in2=mcand.
REQ-031 SHALL contain no other arithmetic adder; cnt increment excepted.

Verification
REQ-032 SHALL cover: N=64, macro off, a=1, b=12 -> product=12, done exactly at t+65, single cycle.
REQ-033 SHALL cover: a=1000, b=4 -> product=4000; with macro on, done at t+4; with macro off, done at t+65.
REQ-034 SHALL cover: a=64'hFFFF_FFFF_FFFF_FFFF, b=2 -> product=64'hFFFF_FFFF_FFFF_FFFE (wrap, carry discarded).
REQ-035 SHALL cover: a=1004, b=4 accepted, then start with a=1008, b=100 at t+5 -> second request ignored, product=4016, then ready=1; a re-issued 1008*100 -> 100800.
REQ-036 SHALL cover: reset at t+10 during 7*9 -> no done pulse, product=0, ready=1 the cycle after reset drops.
REQ-037 SHALL cover: macro on, a=5, b=0 -> done at t+2, product=0.
